// File: rtl/writeback_unit.sv
// writeback_unit
//   Buffers results from the execute/memory stage and drains them, one per
//   cycle and in arrival order, onto the register-file write port. Load data
//   is sign/zero extended on the way out, and writes to x0 or with the
//   "no write" select never assert WE.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid / in_ready      result handshake from the upstream stage
//   in_wen, in_rd, in_src    destination write enable, index, result select
//   in_funct3, in_byte_off   load type and load address bits [1:0]
//   in_alu, in_mem, in_pc4   candidate results
//   flush                    discard everything buffered
//   WE, A3, WD3              registered register-file write port
//   busy                     buffer holds at least one entry
//
// The buffer pops whenever it is non-empty, so with at most one push per
// cycle occupancy stays at one or below; DEPTH only matters if the drain side
// is ever throttled. in_ready still reflects the true full condition.

module writeback_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_src,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_byte_off,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_mem,
  input  logic [31:0] in_pc4,
  input  logic        flush,
  output logic        WE,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_NONE = 2'b11;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  funct3;
    logic [1:0]  byte_off;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
  } entry_t;

  entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               we_q, we_d;
  logic [4:0]         a3_q, a3_d;
  logic [31:0]        wd3_q, wd3_d;

  entry_t             in_entry;
  entry_t             head;
  logic               push;
  logic               pop;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_data;
  logic [31:0]        result;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign busy     = (count_q != '0);
  assign WE       = we_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;

  always_comb begin
    in_entry          = '0;
    in_entry.wen      = in_wen;
    in_entry.rd       = in_rd;
    in_entry.src      = in_src;
    in_entry.funct3   = in_funct3;
    in_entry.byte_off = in_byte_off;
    in_entry.alu      = in_alu;
    in_entry.mem      = in_mem;
    in_entry.pc4      = in_pc4;
  end

  assign head = buf_q[rd_ptr_q];
  assign push = in_valid && in_ready && !flush;
  assign pop  = busy && !flush;

  // Load extraction and extension from the raw word stored with the entry.
  always_comb begin
    ld_byte = 8'h00;
    case (head.byte_off)
      2'd0:    ld_byte = head.mem[7:0];
      2'd1:    ld_byte = head.mem[15:8];
      2'd2:    ld_byte = head.mem[23:16];
      default: ld_byte = head.mem[31:24];
    endcase
    ld_half = head.byte_off[1] ? head.mem[31:16] : head.mem[15:0];
    case (head.funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = head.mem;
    endcase
  end

  always_comb begin
    case (head.src)
      SRC_MEM: result = ld_data;
      SRC_PC4: result = head.pc4;
      default: result = head.alu;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we_d     = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // A3/WD3 follow the popped entry even when the write is suppressed.
        we_d     = head.wen && (head.rd != 5'd0) && (head.src != SRC_NONE);
        a3_d     = head.rd;
        wd3_d    = result;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      a3_q     <= 5'd0;
      wd3_q    <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

  // Storage carries no reset; only occupancy and outputs need a known state.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= in_entry;
    end
  end

endmodule
